udp_tx_arbiter: RTL

Frame-atomic round-robin arbiter that shares one `tx_udp_ip` encapsulator between `N_PORTS` UDP payload sources. Each source presents a 64-bit AXI-Stream payload plus its own destination MAC/IP/UDP and source UDP port. The arbiter grants one source at a time and holds the grant for a whole frame. While a frame is granted it drives that source's payload stream and latched header fields into the encapsulator's payload input and `dst_*`/`src_udp` inputs.

---
 rtl/udp_tx_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one UDP encapsulator between N_PORTS payload sources.
// Define UDP_ARB_STATS_EN to add per-port completed-frame counters on stat_frames.
module udp_tx_arbiter #(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS*64-1:0] s_tdata,
  input  logic [N_PORTS*8-1:0]  s_tkeep,
  input  logic [N_PORTS-1:0]    s_tvalid,
  input  logic [N_PORTS-1:0]    s_tlast,
  output logic [N_PORTS-1:0]    s_tready,
  input  logic [N_PORTS*48-1:0] s_dst_mac,
  input  logic [N_PORTS*32-1:0] s_dst_ip,
  input  logic [N_PORTS*16-1:0] s_dst_udp,
  input  logic [N_PORTS*16-1:0] s_src_udp,
  output logic [63:0]           m_tdata,
  output logic [7:0]            m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [47:0]           dst_mac,
  output logic [31:0]           dst_ip,
  output logic [15:0]           dst_udp,
  output logic [15:0]           src_udp,
  output logic [IDX_W-1:0]      grant_id,
`ifdef UDP_ARB_STATS_EN
  output logic [N_PORTS*32-1:0] stat_frames,
`endif
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] grant_id_r;
  logic [47:0]      dst_mac_r;
  logic [31:0]      dst_ip_r;
  logic [15:0]      dst_udp_r;
  logic [15:0]      src_udp_r;
  logic [IDX_W-1:0] sel_idx_s;
  int               best_dist_s;
  int               dist_s;
  logic             any_req_s;
  logic             last_hs_s;

  // Distance of a port from the round-robin pointer, searching upward with wrap.
  function automatic int rr_distance(input int port, input int ptr);
    int d;
    d = port - ptr;
    rr_distance = (d < 0) ? d + N_PORTS : d;
  endfunction

  assign any_req_s = |s_tvalid;
  assign last_hs_s = (state_r == ST_GRANT) && m_tvalid && m_tready && m_tlast;
  assign busy      = (state_r == ST_GRANT);
  assign grant_id  = grant_id_r;
  assign dst_mac   = dst_mac_r;
  assign dst_ip    = dst_ip_r;
  assign dst_udp   = dst_udp_r;
  assign src_udp   = src_udp_r;

  // Pick the requester closest to rr_ptr going upward.
  always_comb begin
    sel_idx_s   = {IDX_W{1'b0}};
    best_dist_s = N_PORTS;
    dist_s      = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      dist_s = rr_distance(i, int'(rr_ptr_r));
      if (s_tvalid[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        sel_idx_s   = IDX_W'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a grant lasts until the last-beat handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (last_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: zero-latency mux of the granted port onto the encapsulator input.
  always_comb begin
    m_tdata  = 64'd0;
    m_tkeep  = 8'd0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = {N_PORTS{1'b0}};
    if (state_r == ST_GRANT) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (grant_id_r == IDX_W'(i)) begin
          m_tdata     = s_tdata[i*64 +: 64];
          m_tkeep     = s_tkeep[i*8 +: 8];
          m_tvalid    = s_tvalid[i];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end else begin
          s_tready[i] = 1'b0;
        end
      end
    end else begin
      s_tready = {N_PORTS{1'b0}};
    end
  end

  // Grant index, header latch and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id_r <= {IDX_W{1'b0}};
      rr_ptr_r   <= {IDX_W{1'b0}};
      dst_mac_r  <= 48'd0;
      dst_ip_r   <= 32'd0;
      dst_udp_r  <= 16'd0;
      src_udp_r  <= 16'd0;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      grant_id_r <= sel_idx_s;
      for (int i = 0; i < N_PORTS; i++) begin
        if (sel_idx_s == IDX_W'(i)) begin
          dst_mac_r <= s_dst_mac[i*48 +: 48];
          dst_ip_r  <= s_dst_ip[i*32 +: 32];
          dst_udp_r <= s_dst_udp[i*16 +: 16];
          src_udp_r <= s_src_udp[i*16 +: 16];
        end
      end
    end else if (last_hs_s) begin
      rr_ptr_r <= (grant_id_r == IDX_W'(N_PORTS - 1)) ? {IDX_W{1'b0}} : grant_id_r + IDX_W'(1'b1);
    end
  end

`ifdef UDP_ARB_STATS_EN
  logic [31:0] frames_r [N_PORTS];

  // Per-port completed-frame counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        frames_r[i] <= 32'd0;
      end
    end else if (last_hs_s) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (grant_id_r == IDX_W'(i)) begin
          frames_r[i] <= frames_r[i] + 32'd1;
        end
      end
    end
  end

  // Flatten the counters onto the stats port.
  always_comb begin
    stat_frames = {(N_PORTS*32){1'b0}};
    for (int i = 0; i < N_PORTS; i++) begin
      stat_frames[i*32 +: 32] = frames_r[i];
    end
  end
`endif

endmodule
